// File: rtl/reg_access_seq_pkg.sv
// Shared definitions for the register-file access sequencer: default widths,
// zero-register policy and the fetch FSM state encoding.
package reg_access_seq_pkg;

  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 32;
  localparam int ZERO_REG_DEF = 1;

  typedef logic [1:0] seqState_t;

  localparam seqState_t ST_IDLE = 2'd0;
  localparam seqState_t ST_READ = 2'd1;
  localparam seqState_t ST_CAPT = 2'd2;
  localparam seqState_t ST_HOLD = 2'd3;

endpackage

// File: rtl/reg_access_seq_wb_buffer.sv
// One-entry registered write-back stage: every accepted write-back becomes a
// single-cycle register-file write on the following cycle.
module reg_access_seq_wb_buffer
  import reg_access_seq_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wbValid,
  input  logic [AW-1:0] i_wbAddr,
  input  logic [DW-1:0] i_wbData,
  output logic [AW-1:0] o_wrAddr,
  output logic [DW-1:0] o_wrData,
  output logic          o_wrEn
);

  logic          w_wrAccept;
  logic [AW-1:0] r_wrAddr;
  logic [DW-1:0] r_wrData;
  logic          r_wrEn;

  // Register 0 is hardwired to zero, so a write to it never reaches the file.
  assign w_wrAccept = i_wbValid && !((ZERO_REG != 0) && (i_wbAddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrAddr <= '0;
      r_wrData <= '0;
      r_wrEn   <= 1'b0;
    end else begin
      r_wrEn <= w_wrAccept;
      if (w_wrAccept) begin
        r_wrAddr <= i_wbAddr;
        r_wrData <= i_wbData;
      end
    end
  end

  assign o_wrAddr = r_wrAddr;
  assign o_wrData = r_wrData;
  assign o_wrEn   = r_wrEn;

endmodule

// File: rtl/reg_access_seq.sv
// Operand-fetch sequencer for the 2-read/1-write register file: drives read
// addresses, captures registered read data and buffers write-backs.
module reg_access_seq
  import reg_access_seq_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_ra,
  input  logic [AW-1:0] req_rb,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [AW-1:0] rf_r1_addr,
  output logic [AW-1:0] rf_r2_addr,
  input  logic [DW-1:0] rf_r1_dout,
  input  logic [DW-1:0] rf_r2_dout,
  output logic [AW-1:0] rf_r3_addr,
  output logic [DW-1:0] rf_r3_din,
  output logic          rf_r3_wr
);

  seqState_t     r_state;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_rb;
  logic [DW-1:0] r_opA;
  logic [DW-1:0] r_opB;
  logic          r_opValid;
  logic          w_reqReady;
  logic          w_zeroA;
  logic          w_zeroB;

  // Refusing a request while a write-back arrives guarantees the read samples
  // the file no earlier than that write, which the file forwards write-first.
  assign w_reqReady = rst_n && (r_state == ST_IDLE) && !wb_valid;
  assign w_zeroA    = (ZERO_REG != 0) && (r_ra == '0);
  assign w_zeroB    = (ZERO_REG != 0) && (r_rb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ra      <= '0;
      r_rb      <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_opValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && w_reqReady) begin
            r_ra    <= req_ra;
            r_rb    <= req_rb;
            r_state <= ST_READ;
          end
        end
        ST_READ: r_state <= ST_CAPT;
        ST_CAPT: begin
          r_opA     <= w_zeroA ? '0 : rf_r1_dout;
          r_opB     <= w_zeroB ? '0 : rf_r2_dout;
          r_opValid <= 1'b1;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (op_ready) begin
            r_opValid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  reg_access_seq_wb_buffer #(
    .AW       (AW),
    .DW       (DW),
    .ZERO_REG (ZERO_REG)
  ) u_wbBuffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wbValid (wb_valid),
    .i_wbAddr  (wb_addr),
    .i_wbData  (wb_data),
    .o_wrAddr  (rf_r3_addr),
    .o_wrData  (rf_r3_din),
    .o_wrEn    (rf_r3_wr)
  );

  assign req_ready  = w_reqReady;
  assign op_valid   = r_opValid;
  assign op_a       = r_opA;
  assign op_b       = r_opB;
  assign rf_r1_addr = r_ra;
  assign rf_r2_addr = r_rb;

endmodule

// File: tb/tb_reg_access_seq.sv
// Scoreboard bench for reg_access_seq with a write-first register file model
// and an architectural register reference model.
module tb_reg_access_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_ra;
  logic [4:0]  req_rb;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rf_r1_addr;
  logic [4:0]  rf_r2_addr;
  logic [31:0] rf_r1_dout;
  logic [31:0] rf_r2_dout;
  logic [4:0]  rf_r3_addr;
  logic [31:0] rf_r3_din;
  logic        rf_r3_wr;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
  } opExp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wrExp_t;

  logic [31:0] rfMem  [32];
  logic [31:0] refMem [32];
  opExp_t      opQ [$];
  wrExp_t      wrQ [$];
  opExp_t      cur;
  logic        haveCur;
  logic        prevOpValid;
  int          cycle;
  int          vectors;
  int          miscompares;

  reg_access_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ra     (req_ra),
    .req_rb     (req_rb),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rf_r1_addr (rf_r1_addr),
    .rf_r2_addr (rf_r2_addr),
    .rf_r1_dout (rf_r1_dout),
    .rf_r2_dout (rf_r2_dout),
    .rf_r3_addr (rf_r3_addr),
    .rf_r3_din  (rf_r3_din),
    .rf_r3_wr   (rf_r3_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Register file: write port first, then registered reads (write-first).
  always @(posedge clk) begin
    if (rf_r3_wr) rfMem[rf_r3_addr] = rf_r3_din;
    rf_r1_dout <= rfMem[rf_r1_addr];
    rf_r2_dout <= rfMem[rf_r2_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
  endtask

  function automatic logic [31:0] refRead(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : refMem[a];
  endfunction

  // Monitor: updates the architectural model and scores every DUT output.
  always @(negedge clk) begin
    if (!rst_n) begin
      opQ.delete();
      wrQ.delete();
      haveCur     = 1'b0;
      prevOpValid = 1'b0;
      checkOutput("resetOpValid", 32'(op_valid), 32'h0);
      checkOutput("resetWr", 32'(rf_r3_wr), 32'h0);
      checkOutput("resetReqReady", 32'(req_ready), 32'h0);
    end else begin
      if (req_valid && req_ready)
        opQ.push_back('{a: refRead(req_ra), b: refRead(req_rb), cyc: cycle + 3});
      if (wb_valid && (wb_addr != 5'd0)) begin
        refMem[wb_addr] = wb_data;
        wrQ.push_back('{addr: wb_addr, data: wb_data, cyc: cycle + 1});
      end

      if (op_valid && !prevOpValid) begin
        if (opQ.size() == 0) begin
          reportFail("unexpectedOpValid", 32'h1, 32'h0);
          haveCur = 1'b0;
        end else begin
          cur     = opQ.pop_front();
          haveCur = 1'b1;
          checkOutput("opLatency", 32'(cycle), 32'(cur.cyc));
        end
      end
      if (op_valid && haveCur) begin
        checkOutput("opA", op_a, cur.a);
        checkOutput("opB", op_b, cur.b);
      end
      if (opQ.size() > 0 && opQ[0].cyc < cycle) begin
        reportFail("missingOpValid", 32'(op_valid), 32'h1);
        void'(opQ.pop_front());
      end
      prevOpValid = op_valid;

      if (rf_r3_wr) begin
        if (wrQ.size() == 0) begin
          reportFail("unexpectedWrite", {27'h0, rf_r3_addr}, 32'h0);
        end else begin
          wrExp_t w;
          w = wrQ.pop_front();
          checkOutput("wrAddr", {27'h0, rf_r3_addr}, {27'h0, w.addr});
          checkOutput("wrData", rf_r3_din, w.data);
          checkOutput("wrCycle", 32'(cycle), 32'(w.cyc));
        end
      end else if (wrQ.size() > 0 && wrQ[0].cyc <= cycle) begin
        reportFail("missingWrite", 32'(rf_r3_wr), 32'h1);
        void'(wrQ.pop_front());
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = data;
    nextCycle();
    wb_valid = 1'b0;
  endtask

  task automatic issueReq(input logic [4:0] ra, input logic [4:0] rb);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_ra    = ra;
    req_rb    = rb;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = req_ready;
      nextCycle();
      if (acc) break;
    end
    req_valid = 1'b0;
    if (!acc) reportFail("reqAcceptTimeout", 32'h0, 32'h1);
  endtask

  task automatic waitOp(input logic checkConst, input logic [31:0] expA, input logic [31:0] expB);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (op_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportFail("opValidTimeout", 32'h0, 32'h1);
    else if (checkConst) begin
      checkOutput("directedOpA", op_a, expA);
      checkOutput("directedOpB", op_b, expB);
    end
    nextCycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    haveCur     = 1'b0;
    prevOpValid = 1'b0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_ra      = '0;
    req_rb      = '0;
    op_ready    = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v         = $urandom;
      rfMem[i]  = v;
      refMem[i] = v;
    end
    rfMem[0] = 32'hCAFE_0000;

    @(negedge clk);
    checkOutput("resetR1Addr", {27'h0, rf_r1_addr}, 32'h0);
    checkOutput("resetR2Addr", {27'h0, rf_r2_addr}, 32'h0);
    checkOutput("resetR3Addr", {27'h0, rf_r3_addr}, 32'h0);
    checkOutput("resetR3Din", rf_r3_din, 32'h0);
    checkOutput("resetOpA", op_a, 32'h0);
    checkOutput("resetOpB", op_b, 32'h0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    applyStimulus(5'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wb3Wr", 32'(rf_r3_wr), 32'h1);
    checkOutput("wb3Addr", {27'h0, rf_r3_addr}, 32'd3);
    nextCycle();
    issueReq(5'd3, 5'd0);
    waitOp(1'b1, 32'hDEAD_BEEF, 32'h0);

    applyStimulus(5'd0, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wbZeroNoWrite", 32'(rf_r3_wr), 32'h0);
      nextCycle();
    end
    issueReq(5'd0, 5'd0);
    waitOp(1'b1, 32'h0, 32'h0);

    req_valid = 1'b1;
    req_ra    = 5'd5;
    req_rb    = 5'd0;
    wb_valid  = 1'b1;
    wb_addr   = 5'd5;
    wb_data   = 32'h55;
    @(negedge clk);
    checkOutput("hazardReqReady", 32'(req_ready), 32'h0);
    nextCycle();
    wb_valid = 1'b0;
    issueReq(5'd5, 5'd0);
    waitOp(1'b1, 32'h55, 32'h0);

    op_ready = 1'b0;
    issueReq(5'd7, 5'd1);
    waitOp(1'b0, 32'h0, 32'h0);
    applyStimulus(5'd7, 32'hAA);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("holdOpValid", 32'(op_valid), 32'h1);
      nextCycle();
    end
    op_ready = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("releaseOpValid", 32'(op_valid), 32'h0);
    nextCycle();
    issueReq(5'd7, 5'd7);
    waitOp(1'b1, 32'hAA, 32'hAA);

    issueReq(5'd2, 5'd4);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetOpValid", 32'(op_valid), 32'h0);
    checkOutput("midResetWr", 32'(rf_r3_wr), 32'h0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postResetIdle", 32'(req_ready), 32'h1);
    nextCycle();
    issueReq(5'd2, 5'd4);
    waitOp(1'b1, refRead(5'd2), refRead(5'd4));

    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) begin
        wb_valid = 1'b1;
        wb_addr  = 5'(i);
        wb_data  = 32'h1000_0000 + 32'(i);
      end else begin
        wb_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 1) begin
        checkOutput("b2bWr", 32'(rf_r3_wr), 32'h1);
        checkOutput("b2bAddr", {27'h0, rf_r3_addr}, 32'(i - 1));
        checkOutput("b2bData", rf_r3_din, 32'h1000_0000 + 32'(i - 1));
      end
      nextCycle();
    end
    @(negedge clk);
    checkOutput("b2bEnd", 32'(rf_r3_wr), 32'h0);
    nextCycle();

    for (int c = 0; c < 400; c++) begin
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      req_valid = ($urandom_range(0, 1) == 1);
      req_ra    = 5'($urandom_range(0, 7));
      req_rb    = 5'($urandom_range(0, 7));
      op_ready  = ($urandom_range(0, 3) != 0);
      nextCycle();
    end
    wb_valid  = 1'b0;
    req_valid = 1'b0;
    op_ready  = 1'b1;
    repeat (10) nextCycle();
    checkOutput("opQueueDrained", 32'(opQ.size()), 32'h0);
    checkOutput("wrQueueDrained", 32'(wrQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
